tex_fetch_arbiter: RTL and testbench

Shares the single texture-controller command interface (load_texture / get_rgba / TexNum) between two rasterizer requesters. Each request names a texture and a pixel count. The arbiter grants round-robin and sequences the load, then the per-pixel get pulses at the controller's command spacing. It captures each 32-bit RGBA word after the fixed read latency and returns it to the owning requester. It sits between the rasteriser lanes and the texture controller, and has exactly one transaction in flight.

---
 rtl/tex_fetch_arbiter_pkg.sv | 32 +++
 rtl/tex_fetch_arbiter_if.sv | 46 ++++
 rtl/tex_rr_arb2.sv | 36 +++
 rtl/tex_fetch_arbiter.sv | 168 ++++++++++++++++
 tb/tb_tex_fetch_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tex_fetch_arbiter_pkg.sv
// Shared types and constants for the texture-fetch arbiter slice.
//   fetch_state_t : arbiter sequencing states
//   TEX_NUM_W     : texture number width
//   RGBA_W        : packed {red,green,blue,alpha} word width
//   *_LSB, CH_W   : channel positions inside an rgba word (MSB = red)
//   max_int       : elaboration-time helper
package tex_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_LOAD,
    S_WAIT,
    S_CAPTURE,
    S_GET,
    S_DONE
  } fetch_state_t;

  localparam int TEX_NUM_W = 8;
  localparam int RGBA_W    = 32;

  localparam int CH_W      = 8;
  localparam int RED_LSB   = 24;
  localparam int GREEN_LSB = 16;
  localparam int BLUE_LSB  = 8;
  localparam int ALPHA_LSB = 0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tex_fetch_arbiter_if.sv
// Bundle of the two requester lanes and the texture-controller command port.
//   r0_*/r1_*   : request (req, tex_num, count) and response (ack, pix_valid, done, err)
//   pix_rgba    : captured pixel returned to the owning requester
//   tc_*        : texture-controller command/data (tex_num, load, get, rgba)
// modport master : the arbiter
// modport slave  : the environment (rasteriser lanes + texture controller)
interface tex_fetch_arbiter_if #(
  parameter int CNT_W = 8
);
  import tex_pkg::*;

  logic                 r0_req;
  logic [TEX_NUM_W-1:0] r0_tex_num;
  logic [CNT_W-1:0]     r0_count;
  logic                 r1_req;
  logic [TEX_NUM_W-1:0] r1_tex_num;
  logic [CNT_W-1:0]     r1_count;

  logic                 r0_ack;
  logic                 r1_ack;
  logic                 r0_pix_valid;
  logic                 r1_pix_valid;
  logic                 r0_done;
  logic                 r1_done;
  logic                 r0_err;
  logic                 r1_err;
  logic [RGBA_W-1:0]    pix_rgba;

  logic [TEX_NUM_W-1:0] tc_tex_num;
  logic                 tc_load;
  logic                 tc_get;
  logic [RGBA_W-1:0]    tc_rgba;

  modport master (
    input  r0_req, r0_tex_num, r0_count, r1_req, r1_tex_num, r1_count, tc_rgba,
    output r0_ack, r1_ack, r0_pix_valid, r1_pix_valid, r0_done, r1_done,
           r0_err, r1_err, pix_rgba, tc_tex_num, tc_load, tc_get
  );

  modport slave (
    output r0_req, r0_tex_num, r0_count, r1_req, r1_tex_num, r1_count, tc_rgba,
    input  r0_ack, r1_ack, r0_pix_valid, r1_pix_valid, r0_done, r1_done,
           r0_err, r1_err, pix_rgba, tc_tex_num, tc_load, tc_get
  );

endinterface

// File: rtl/tex_rr_arb2.sv
// Two-way round-robin arbiter with a last-grant pointer.
//   clk, reset : clock, async active-low reset
//   req[1:0]   : request vector
//   advance    : accept the current grant and move the pointer
//   grant[1:0] : one-hot grant (combinational)
module tex_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  import tex_pkg::*;

  // 1 = requester 1 was served last, so requester 0 wins a tie
  logic last;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last <= 1'b1;
    end else if (advance && (|grant)) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/tex_fetch_arbiter.sv
// Shares one texture-controller command port between two rasteriser lanes.
// One transaction in flight: grant, load, then per-pixel gets spaced by
// max(RD_LAT, CMD_GAP)+1 cycles, each rgba word returned to the owner.
//   clk, reset : clock, async active-low reset
//   bus        : tex_fetch_arbiter_if.master (requesters + texture controller)
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | no transaction; arbitrate on any req (ack issued on exit)
// S_GRANT   | ack visible; classify count / texture number
// S_LOAD    | tc_load pulse visible
// S_WAIT    | wait counter running toward the capture slot
// S_CAPTURE | tc_rgba valid; register it, pix_valid follows
// S_GET     | tc_get pulse visible
// S_DONE    | transaction over; done (and err) pulse on exit
module tex_fetch_arbiter #(
  parameter int NUM_TEX = 50,
  parameter int CMD_GAP = 2,
  parameter int RD_LAT  = 3,
  parameter int CNT_W   = 8
) (
  input  logic         clk,
  input  logic         reset,
  tex_fetch_arbiter_if.master bus
);
  import tex_pkg::*;

  localparam int SLOT_L = max_int(RD_LAT, CMD_GAP);
  localparam int WAIT_W = (SLOT_L > 1) ? $clog2(SLOT_L) : 1;
  localparam logic [WAIT_W-1:0]    WAIT_LOAD  = WAIT_W'(SLOT_L - 1);
  localparam logic [TEX_NUM_W-1:0] NUM_TEX_V  = TEX_NUM_W'(NUM_TEX);

  fetch_state_t         state;
  logic                 owner;
  logic [TEX_NUM_W-1:0] tex_q;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     remaining;
  logic [WAIT_W-1:0]    wait_cnt;
  logic                 err_flag;

  logic [1:0]           ack_q;
  logic [1:0]           pix_valid_q;
  logic [1:0]           done_q;
  logic [1:0]           err_q;
  logic [RGBA_W-1:0]    pix_q;
  logic [TEX_NUM_W-1:0] tc_tex_q;
  logic                 tc_load_q;
  logic                 tc_get_q;

  logic [1:0]           req;
  logic [1:0]           grant;
  logic                 advance;
  logic                 tex_ok;

  assign req     = {bus.r1_req, bus.r0_req};
  assign advance = (state == S_IDLE) && (|req);
  assign tex_ok  = (tex_q != '0) && (tex_q <= NUM_TEX_V);

  tex_rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (advance),
    .grant   (grant)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      tex_q       <= '0;
      count_q     <= '0;
      remaining   <= '0;
      wait_cnt    <= '0;
      err_flag    <= 1'b0;
      ack_q       <= '0;
      pix_valid_q <= '0;
      done_q      <= '0;
      err_q       <= '0;
      pix_q       <= '0;
      tc_tex_q    <= '0;
      tc_load_q   <= 1'b0;
      tc_get_q    <= 1'b0;
    end else begin
      ack_q       <= '0;
      pix_valid_q <= '0;
      done_q      <= '0;
      err_q       <= '0;
      tc_load_q   <= 1'b0;
      tc_get_q    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // Winner is chosen on the way into GRANT so ack is visible there.
          if (|req) begin
            state   <= S_GRANT;
            ack_q   <= grant;
            owner   <= grant[1];
            tex_q   <= grant[1] ? bus.r1_tex_num : bus.r0_tex_num;
            count_q <= grant[1] ? bus.r1_count   : bus.r0_count;
          end
        end
        S_GRANT: begin
          if (count_q == '0) begin
            state <= S_DONE;
          end else if (!tex_ok) begin
            err_flag <= 1'b1;
            state    <= S_DONE;
          end else begin
            tc_load_q <= 1'b1;
            tc_tex_q  <= tex_q;
            remaining <= count_q;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          wait_cnt <= WAIT_LOAD;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          // <=1 also covers a zero reload when the slot length is 1
          if (wait_cnt <= WAIT_W'(1)) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          pix_q <= {tc_rgba_ch(RED_LSB), tc_rgba_ch(GREEN_LSB),
                    tc_rgba_ch(BLUE_LSB), tc_rgba_ch(ALPHA_LSB)};
          pix_valid_q[owner] <= 1'b1;
          remaining <= remaining - 1'b1;
          if (remaining == CNT_W'(1)) begin
            state <= S_DONE;
          end else begin
            tc_get_q <= 1'b1;
            state    <= S_GET;
          end
        end
        S_GET: begin
          wait_cnt <= WAIT_LOAD;
          state    <= S_WAIT;
        end
        S_DONE: begin
          done_q[owner] <= 1'b1;
          err_q[owner]  <= err_flag;
          err_flag      <= 1'b0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  function automatic logic [CH_W-1:0] tc_rgba_ch(input int lsb);
    return bus.tc_rgba[lsb +: CH_W];
  endfunction

  assign bus.r0_ack       = ack_q[0];
  assign bus.r1_ack       = ack_q[1];
  assign bus.r0_pix_valid = pix_valid_q[0];
  assign bus.r1_pix_valid = pix_valid_q[1];
  assign bus.r0_done      = done_q[0];
  assign bus.r1_done      = done_q[1];
  assign bus.r0_err       = err_q[0];
  assign bus.r1_err       = err_q[1];
  assign bus.pix_rgba     = pix_q;
  assign bus.tc_tex_num   = tc_tex_q;
  assign bus.tc_load      = tc_load_q;
  assign bus.tc_get       = tc_get_q;

endmodule

// File: tb/tb_tex_fetch_arbiter.sv
// Directed bench for tex_fetch_arbiter: default instance (RD_LAT=3) and an
// override instance (RD_LAT=1, CMD_GAP=2), each with a texture-controller model.
module tb_tex_fetch_arbiter;

  localparam int NUM_TEX = 50;
  localparam int CMD_GAP = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tex_fetch_arbiter_if #(.CNT_W(8)) bus ();
  tex_fetch_arbiter_if #(.CNT_W(8)) bus2 ();

  tex_fetch_arbiter u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  tex_fetch_arbiter #(.RD_LAT(1), .CMD_GAP(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] tex_word(input int tex, input int idx);
    return {8'(tex), 8'(idx), 8'(tex * 5 + idx), 8'(8'hA0 ^ 8'(idx))};
  endfunction

  // Texture-controller model, RD_LAT=3: word valid 3 cycles after the pulse, then held.
  logic [31:0] m1_w0, m1_w1;
  logic        m1_v0, m1_v1;
  int          m1_tex, m1_idx;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m1_v0 <= 1'b0; m1_v1 <= 1'b0; m1_w0 <= '0; m1_w1 <= '0;
      m1_tex <= 0; m1_idx <= 0; bus.tc_rgba <= '0;
    end else begin
      m1_v0 <= bus.tc_load | bus.tc_get;
      if (bus.tc_load) begin
        m1_tex <= int'(bus.tc_tex_num);
        m1_idx <= 0;
        m1_w0  <= tex_word(int'(bus.tc_tex_num), 0);
      end else if (bus.tc_get) begin
        m1_idx <= m1_idx + 1;
        m1_w0  <= tex_word(m1_tex, m1_idx + 1);
      end
      m1_v1 <= m1_v0;
      m1_w1 <= m1_w0;
      if (m1_v1) bus.tc_rgba <= m1_w1;
    end
  end

  // Texture-controller model, RD_LAT=1.
  int m2_tex, m2_idx;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m2_tex <= 0; m2_idx <= 0; bus2.tc_rgba <= '0;
    end else if (bus2.tc_load) begin
      m2_tex <= int'(bus2.tc_tex_num);
      m2_idx <= 0;
      bus2.tc_rgba <= tex_word(int'(bus2.tc_tex_num), 0);
    end else if (bus2.tc_get) begin
      m2_idx <= m2_idx + 1;
      bus2.tc_rgba <= tex_word(m2_tex, m2_idx + 1);
    end
  end

  // Command spacing on both controller ports.
  int last1 = -100;
  int last2 = -100;
  always @(negedge clk) begin
    if (bus.tc_load || bus.tc_get) begin
      check("cmd_gap0", 64'((bus.tc_load && bus.tc_get) || (cyc - last1 < CMD_GAP) ? 0 : 1), 64'd1);
      last1 = cyc;
    end
    if (bus2.tc_load || bus2.tc_get) begin
      check("cmd_gap1", 64'((bus2.tc_load && bus2.tc_get) || (cyc - last2 < CMD_GAP) ? 0 : 1), 64'd1);
      last2 = cyc;
    end
  end

  function automatic logic [9:0] get_vec(input int which);
    if (which == 0)
      return {bus.r0_ack, bus.r1_ack, bus.r0_pix_valid, bus.r1_pix_valid, bus.r0_done,
              bus.r1_done, bus.r0_err, bus.r1_err, bus.tc_load, bus.tc_get};
    return {bus2.r0_ack, bus2.r1_ack, bus2.r0_pix_valid, bus2.r1_pix_valid, bus2.r0_done,
            bus2.r1_done, bus2.r0_err, bus2.r1_err, bus2.tc_load, bus2.tc_get};
  endfunction

  function automatic logic [31:0] get_pix(input int which);
    return (which == 0) ? bus.pix_rgba : bus2.pix_rgba;
  endfunction

  function automatic logic [7:0] get_tex(input int which);
    return (which == 0) ? bus.tc_tex_num : bus2.tc_tex_num;
  endfunction

  typedef struct {
    int rq;
    int tex;
    int cnt;
    int req_at;  // cycle the requester raises req
    int start;   // ack expected at start+1
  } txn_t;

  txn_t plan[$];

  function automatic bit tex_bad(input int tex);
    return (tex == 0) || (tex > NUM_TEX);
  endfunction

  // Expected pulse vector at cycle rel; slot = max(RD_LAT, CMD_GAP).
  // Bits: r0_ack r1_ack r0_pv r1_pv r0_done r1_done r0_err r1_err load get
  // Rejected requests: ack, GRANT classifies, DONE state, done pulse after it.
  function automatic logic [9:0] exp_txn(input txn_t t, input int rel, input int slot);
    logic [9:0] v;
    int p;
    v = '0;
    p = slot + 1;
    if (rel == t.start + 1) v[9 - t.rq] = 1'b1;
    if (t.cnt == 0) begin
      if (rel == t.start + 3) v[5 - t.rq] = 1'b1;
    end else if (tex_bad(t.tex)) begin
      if (rel == t.start + 3) begin
        v[5 - t.rq] = 1'b1;
        v[3 - t.rq] = 1'b1;
      end
    end else begin
      if (rel == t.start + 2) v[1] = 1'b1;
      for (int k = 1; k < t.cnt; k++) if (rel == t.start + 2 + k * p) v[0] = 1'b1;
      for (int k = 1; k <= t.cnt; k++) if (rel == t.start + 2 + k * p) v[7 - t.rq] = 1'b1;
      if (rel == t.start + 2 + t.cnt * p + 1) v[5 - t.rq] = 1'b1;
    end
    return v;
  endfunction

  function automatic int pix_idx(input txn_t t, input int rel, input int slot);
    if (t.cnt == 0 || tex_bad(t.tex)) return -1;
    for (int k = 1; k <= t.cnt; k++) if (rel == t.start + 2 + k * (slot + 1)) return k - 1;
    return -1;
  endfunction

  task automatic drive(input int which, input int rq, input logic r, input int tex, input int cnt);
    if (which == 0 && rq == 0) begin bus.r0_req = r; bus.r0_tex_num = 8'(tex); bus.r0_count = 8'(cnt); end
    else if (which == 0)       begin bus.r1_req = r; bus.r1_tex_num = 8'(tex); bus.r1_count = 8'(cnt); end
    else if (rq == 0)          begin bus2.r0_req = r; bus2.r0_tex_num = 8'(tex); bus2.r0_count = 8'(cnt); end
    else                       begin bus2.r1_req = r; bus2.r1_tex_num = 8'(tex); bus2.r1_count = 8'(cnt); end
  endtask

  // Called just after a posedge; that cycle is rel=0.
  task automatic run_plan(input int which, input int slot, input int ncyc, input string tag);
    logic       r;
    int         tx, cn, k;
    logic [9:0] expv;
    for (int rel = 0; rel < ncyc; rel++) begin
      for (int rq = 0; rq < 2; rq++) begin
        r = 1'b0; tx = 0; cn = 0;
        foreach (plan[i])
          if (!r && plan[i].rq == rq && rel >= plan[i].req_at && rel <= plan[i].start + 1) begin
            r = 1'b1; tx = plan[i].tex; cn = plan[i].cnt;
          end
        drive(which, rq, r, tx, cn);
      end
      @(negedge clk);
      expv = '0;
      foreach (plan[i]) expv |= exp_txn(plan[i], rel, slot);
      check({tag, "_pulses"}, 64'(get_vec(which)), 64'(expv));
      foreach (plan[i]) begin
        k = pix_idx(plan[i], rel, slot);
        if (k >= 0) check({tag, "_rgba"}, 64'(get_pix(which)), 64'(tex_word(plan[i].tex, k)));
        if (rel == plan[i].start + 2 && plan[i].cnt != 0 && !tex_bad(plan[i].tex))
          check({tag, "_tex"}, 64'(get_tex(which)), 64'(plan[i].tex));
      end
      @(posedge clk);
      #1;
    end
    drive(which, 0, 1'b0, 0, 0);
    drive(which, 1, 1'b0, 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drive(0, 0, 1'b0, 0, 0); drive(0, 1, 1'b0, 0, 0);
    drive(1, 0, 1'b0, 0, 0); drive(1, 1, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pulses", 64'(get_vec(0)), 64'd0);
    check("reset_pix",    64'(get_pix(0)), 64'd0);
    check("reset_tex",    64'(get_tex(0)), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: single pixel on r0
    plan.delete();
    plan.push_back('{0, 3, 1, 0, 0});
    run_plan(0, 3, 10, "t1_r0_single");

    // 2: four pixels on r1
    plan.delete();
    plan.push_back('{1, 7, 4, 0, 0});
    run_plan(0, 3, 22, "t2_r1_burst");

    // 3: both held, alternating grants
    plan.delete();
    plan.push_back('{0, 4, 1, 0, 0});
    plan.push_back('{1, 9, 1, 0, 7});
    plan.push_back('{0, 4, 1, 0, 14});
    plan.push_back('{1, 9, 1, 0, 21});
    run_plan(0, 3, 32, "t3_rr");

    // 4: texture 0, texture 51, count 0
    plan.delete();
    plan.push_back('{0, 0, 1, 0, 0});
    plan.push_back('{0, 51, 1, 4, 4});
    plan.push_back('{0, 5, 0, 8, 8});
    run_plan(0, 3, 13, "t4_reject");

    // 5: reset during WAIT of a 5-pixel transaction
    drive(0, 0, 1'b1, 6, 5);
    @(posedge clk); #1;
    drive(0, 0, 1'b0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5_pre_tex", 64'(get_tex(0)), 64'd6);
    #2 reset = 1'b0;
    #1;
    check("t5_abort_outs", {14'd0, get_vec(0), get_pix(0), get_tex(0)}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t5_held_outs", {14'd0, get_vec(0), get_pix(0), get_tex(0)}, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    plan.delete();
    plan.push_back('{1, 8, 2, 0, 0});
    run_plan(0, 3, 13, "t5_after_rst");

    // 6: RD_LAT=1, CMD_GAP=2 -> slot 2, cadence 3
    plan.delete();
    plan.push_back('{0, 2, 3, 0, 0});
    run_plan(1, 2, 14, "t6_lat1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
